score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter STATE_BITS, default 1; game_state width is STATE_BITS+1.
REQ-002 SHALL have parameter STATE_RESET, default 2'd0; game-state code for reset.
REQ-003 SHALL have parameter STATE_PAUSE, default 2'd1; game-state code for pause.
REQ-004 SHALL have parameter STATE_GAME, default 2'd2; game-state code for active play.
REQ-005 SHALL have parameter MAX_LIFE, default 3'd4; starting and maximum life.
REQ-006 SHALL have parameter COMBO_STEP, default 10; combo interval per multiplier step.
REQ-007 SHALL have parameter LIFE_REGAIN, default 50; combo interval per regained life.
REQ-008 clk  input  1  single system clock; all logic on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 game_state  input  STATE_BITS+1  game state from the state generator.
REQ-011 display_combo_en  input  1  selects max_combo on display_value.
REQ-012 hit_valid  input  1  one-cycle pulse from arrow judge; qualifies hit_grade.
REQ-013 hit_grade  input  2  00 miss, 01 good, 10 great, 11 perfect.
REQ-014 life  output  3  remaining life; fed back to the state generator.
REQ-015 score  output  14  accumulated score, saturating at 9999.
REQ-016 combo  output  10  current consecutive-hit count, saturating at 999.
REQ-017 max_combo  output  10  highest combo since last clear.
REQ-018 display_value  output  14  registered mux: max_combo when display_combo_en=1, else score.
REQ-019 game_over  output  1  high while the FSM is in S_OVER.

Function
REQ-020 SHALL implement FSM S_IDLE, S_PLAY, S_HOLD, S_OVER; all outputs registered.
REQ-021 From S_IDLE/S_PLAY/S_HOLD, next state SHALL be: S_IDLE on STATE_RESET, S_PLAY on STATE_GAME, S_HOLD on STATE_PAUSE or any undefined code.
REQ-022 S_OVER SHALL exit only on STATE_RESET, to S_IDLE; all other codes hold S_OVER.
REQ-023 In S_IDLE, each edge SHALL load life=MAX_LIFE and clear score, combo, max_combo.
REQ-024 Hits SHALL be accepted only when the registered FSM state is S_PLAY and hit_valid=1; results visible on the next edge (latency 1); all other hit_valid pulses are dropped.
REQ-025 Multiplier SHALL be 1+floor(combo/COMBO_STEP), capped at 4, using combo before the hit.
REQ-026 Non-miss hit SHALL add grade (1/2/3) x multiplier to score, saturating at 9999, and increment combo, saturating at 999.
REQ-027 Miss SHALL clear combo to 0, leave score unchanged, and decrement life, saturating at 0.
REQ-028 max_combo SHALL update on the same edge as combo to max(max_combo, new combo).
REQ-029 On the edge where life becomes 0, FSM SHALL enter S_OVER; game_over asserts on that edge.
REQ-030 Miss with life already 0 SHALL be impossible (S_OVER blocks hits); no wrap-around of any counter SHALL occur.
REQ-031 display_value SHALL reflect inputs with one-cycle latency in every FSM state.
REQ-032 S_HOLD and S_OVER SHALL hold life, score, combo and max_combo unchanged.

Reset
REQ-033 rst_n=0 SHALL immediately force FSM=S_IDLE, life=MAX_LIFE, score=0, combo=0, max_combo=0, display_value=0, game_over=0, including mid-hit or in S_OVER.
REQ-034 Release of rst_n SHALL take effect on the first rising clk edge after deassertion; game_state=STATE_RESET SHALL act as a synchronous clear with the same values.

Configuration
REQ-035 Macro SCORE_KEEPER_LIFE_REGAIN_EN defined: a non-miss hit whose new combo is a nonzero multiple of LIFE_REGAIN SHALL increment life, capped at MAX_LIFE.
REQ-036 Macro undefined: life SHALL never increase except by reset or S_IDLE load.

Verification
REQ-037 Pulse rst_n low mid-play -> life=4, score=0, combo=0, max_combo=0, game_over=0, display_value=0 with no clock edge required.
REQ-038 STATE_GAME, 12 perfect hits -> combo=12, max_combo=12, score=42 (10x3 + 2x6).
REQ-039 Then one miss -> combo=0, life=3, score=42, max_combo=12.
REQ-040 STATE_PAUSE, 5 perfect pulses, display_combo_en=1 -> no counter change; display_value=12 one cycle later, 42 once display_combo_en=0.
REQ-041 From life=3 in STATE_GAME, 3 misses -> life=0, game_over=1; perfect hits and STATE_GAME/STATE_PAUSE ignored; STATE_RESET -> life=4, game_over=0 next edge.
REQ-042 From life=3, 50 consecutive good hits -> life=4 with SCORE_KEEPER_LIFE_REGAIN_EN defined, life=3 without; 999+ hits -> combo holds 999.

Source files
------------

// File: rtl/score_keeper.sv
// Rhythm-game score keeper: grades hits into score/combo/life and tracks game-over.
// Optional life regain on combo milestones is enabled by defining SCORE_KEEPER_LIFE_REGAIN_EN.
module score_keeper #(
  parameter int                  STATE_BITS  = 1,
  parameter logic [STATE_BITS:0] STATE_RESET = 2'd0,
  parameter logic [STATE_BITS:0] STATE_PAUSE = 2'd1,
  parameter logic [STATE_BITS:0] STATE_GAME  = 2'd2,
  parameter logic [2:0]          MAX_LIFE    = 3'd4,
  parameter int                  COMBO_STEP  = 10,
  parameter int                  LIFE_REGAIN = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STATE_BITS:0]   game_state,
  input  logic                  display_combo_en,
  input  logic                  hit_valid,
  input  logic [1:0]            hit_grade,
  output logic [2:0]            life,
  output logic [13:0]           score,
  output logic [9:0]            combo,
  output logic [9:0]            max_combo,
  output logic [13:0]           display_value,
  output logic                  game_over
);

`ifdef SCORE_KEEPER_LIFE_REGAIN_EN
  localparam bit REGAIN_EN = 1'b1;
`else
  localparam bit REGAIN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_OVER} state_e;

  state_e      state_q, state_d;
  logic [2:0]  life_q, life_d;
  logic [13:0] score_q, score_d, disp_q, disp_d, sum;
  logic [9:0]  combo_q, combo_d, max_q, max_d, tier;
  logic [2:0]  mult;
  logic [3:0]  points;
  logic        over_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Running out of life wins over the requested game state, except a reset request.
  always_comb begin
    state_d = state_q;
    if (game_state == STATE_RESET)     state_d = S_IDLE;
    else if (state_q == S_OVER)        state_d = S_OVER;
    else if (life_d == 3'd0)           state_d = S_OVER;
    else if (game_state == STATE_GAME) state_d = S_PLAY;
    else if (game_state == STATE_PAUSE) state_d = S_HOLD;
    else                               state_d = S_HOLD;
  end

  always_comb begin
    life_d  = life_q;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    tier    = combo_q / 10'(COMBO_STEP);
    mult    = (tier >= 10'd3) ? 3'd4 : 3'(tier) + 3'd1;
    points  = {2'b00, hit_grade} * {1'b0, mult};
    sum     = score_q + {10'd0, points};
    if (state_q == S_IDLE || game_state == STATE_RESET) begin
      life_d  = MAX_LIFE;
      score_d = 14'd0;
      combo_d = 10'd0;
      max_d   = 10'd0;
    end else if (state_q == S_PLAY && hit_valid) begin
      if (hit_grade == 2'b00) begin
        combo_d = 10'd0;
        life_d  = (life_q == 3'd0) ? 3'd0 : life_q - 3'd1;
      end else begin
        score_d = (sum > 14'd9999) ? 14'd9999 : sum;
        combo_d = (combo_q == 10'd999) ? combo_q : combo_q + 10'd1;
        max_d   = (combo_d > max_q) ? combo_d : max_q;
        if (REGAIN_EN && (combo_d % 10'(LIFE_REGAIN)) == 10'd0 && life_q < MAX_LIFE)
          life_d = life_q + 3'd1;
      end
    end
    // Mux the next-state values so a synchronous clear also zeroes the display.
    disp_d = display_combo_en ? {4'd0, max_d} : score_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      life_q  <= MAX_LIFE;
      score_q <= 14'd0;
      combo_q <= 10'd0;
      max_q   <= 10'd0;
      disp_q  <= 14'd0;
      over_q  <= 1'b0;
    end else begin
      life_q  <= life_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      disp_q  <= disp_d;
      over_q  <= (state_d == S_OVER);
    end
  end

  assign life          = life_q;
  assign score         = score_q;
  assign combo         = combo_q;
  assign max_combo     = max_q;
  assign display_value = disp_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: game-level model checked every cycle plus literal checkpoints.
module tb_score_keeper;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [1:0]  game_state = 2'd0;
  logic        display_combo_en = 1'b0, hit_valid = 1'b0;
  logic [1:0]  hit_grade = 2'd0;
  logic [2:0]  life;
  logic [13:0] score, display_value;
  logic [9:0]  combo, max_combo;
  logic        game_over;

  score_keeper dut (
    .clk(clk), .rst_n(rst_n), .game_state(game_state),
    .display_combo_en(display_combo_en), .hit_valid(hit_valid), .hit_grade(hit_grade),
    .life(life), .score(score), .combo(combo), .max_combo(max_combo),
    .display_value(display_value), .game_over(game_over)
  );

  always #5 clk = ~clk;

`ifdef SCORE_KEEPER_LIFE_REGAIN_EN
  localparam int REGAIN_LIFE = 4;
`else
  localparam int REGAIN_LIFE = 3;
`endif

  // mode: 0 waiting, 1 playing, 2 paused, 3 game over
  typedef struct {
    int life; int score; int combo; int maxc; int disp; int mode;
  } mdl_t;

  mdl_t m;
  int   n_cmp = 0, n_bad = 0;
  bit   started = 1'b0;

  function automatic mdl_t fresh();
    mdl_t r;
    r.life = 4; r.score = 0; r.combo = 0; r.maxc = 0; r.disp = 0; r.mode = 0;
    return r;
  endfunction

  function automatic mdl_t step_m(mdl_t c, int gs, bit hv, int g, bit en);
    mdl_t r = c;
    int mul;
    if (gs == 0) begin
      r = fresh();
    end else begin
      if (c.mode == 1 && hv) begin
        if (g == 0) begin
          r.combo = 0;
          if (r.life > 0) r.life = r.life - 1;
        end else begin
          mul = c.combo / 10 + 1;
          if (mul > 4) mul = 4;
          r.score = c.score + g * mul;
          if (r.score > 9999) r.score = 9999;
          r.combo = (c.combo >= 999) ? 999 : c.combo + 1;
          if (r.combo > r.maxc) r.maxc = r.combo;
`ifdef SCORE_KEEPER_LIFE_REGAIN_EN
          if (r.combo % 50 == 0 && r.life < 4) r.life = r.life + 1;
`endif
        end
      end
      if (c.mode == 3)       r.mode = 3;
      else if (r.life == 0)  r.mode = 3;
      else if (gs == 2)      r.mode = 1;
      else                   r.mode = 2;
    end
    r.disp = en ? r.maxc : r.score;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= fresh();
    else        m <= step_m(m, int'(game_state), hit_valid, int'(hit_grade), display_combo_en);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model life",  int'(life),          m.life);
      chk("model score", int'(score),         m.score);
      chk("model combo", int'(combo),         m.combo);
      chk("model max",   int'(max_combo),     m.maxc);
      chk("model disp",  int'(display_value), m.disp);
      chk("model over",  int'(game_over),     (m.mode == 3) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hits(input int n, input logic [1:0] g);
    hit_valid = 1'b1;
    hit_grade = g;
    tick(n);
    hit_valid = 1'b0;
  endtask

  task automatic lit(input string tag, input int l, input int s, input int c,
                     input int mx, input int d, input int go);
    chk({tag, " life"},  int'(life),          l);
    chk({tag, " score"}, int'(score),         s);
    chk({tag, " combo"}, int'(combo),         c);
    chk({tag, " max"},   int'(max_combo),     mx);
    chk({tag, " disp"},  int'(display_value), d);
    chk({tag, " over"},  int'(game_over),     go);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 lit("por", 4, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;
    tick(2);
    lit("idle", 4, 0, 0, 0, 0, 0);

    game_state = 2'd2;
    tick(1);
    hits(12, 2'd3);
    lit("12 perfect", 4, 42, 12, 12, 42, 0);
    hits(1, 2'd0);
    lit("miss", 3, 42, 0, 12, 42, 0);

    game_state = 2'd1;
    display_combo_en = 1'b1;
    tick(1);
    hits(5, 2'd3);
    tick(1);
    lit("pause max", 3, 42, 0, 12, 12, 0);
    display_combo_en = 1'b0;
    tick(1);
    lit("pause score", 3, 42, 0, 12, 42, 0);

    game_state = 2'd3;
    tick(1);
    hits(3, 2'd2);
    lit("undef code", 3, 42, 0, 12, 42, 0);

    game_state = 2'd2;
    tick(1);
    hits(3, 2'd0);
    lit("over", 0, 42, 0, 12, 42, 1);
    hits(3, 2'd3);
    game_state = 2'd1;
    hits(2, 2'd3);
    lit("over hold", 0, 42, 0, 12, 42, 1);
    game_state = 2'd0;
    tick(1);
    lit("sync clear", 4, 0, 0, 0, 0, 0);

    game_state = 2'd2;
    tick(1);
    hits(1, 2'd0);
    hits(50, 2'd1);
    lit("50 good", REGAIN_LIFE, 140, 50, 50, 140, 0);
    hits(960, 2'd3);
    lit("saturate", REGAIN_LIFE, 9999, 999, 999, 9999, 0);

    hit_valid = 1'b1;
    hit_grade = 2'd3;
    #2 rst_n = 1'b0;
    #1 lit("mid reset", 4, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    hit_valid = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
